// File: rtl/lr_rot_pipe_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rot_pkg : opcode encoding shared by the rotator/shifter pipeline |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package rot_pkg;

  typedef enum logic [2:0] {
    ROT_PASS = 3'b000,
    ROT_ROL  = 3'b001,
    ROT_ROR  = 3'b010,
    ROT_SHL  = 3'b011,
    ROT_SHR  = 3'b100,
    ROT_SRA  = 3'b101,
    ROT_REV  = 3'b110,
    ROT_RSVD = 3'b111
  } rot_op_e;

endpackage
`default_nettype wire

// File: rtl/lr_rot_pipe_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lr_rot_stage : one log-shifter layer, moves data by SHIFT if en  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module lr_rot_stage
  import rot_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  rot_op_e          op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = data;
    if (en) begin
      case (op)
        ROT_ROL: result = {data[WIDTH-SHIFT-1:0], data[WIDTH-1:WIDTH-SHIFT]};
        ROT_ROR: result = {data[SHIFT-1:0], data[WIDTH-1:SHIFT]};
        ROT_SHL: result = {data[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
        ROT_SHR: result = {{SHIFT{1'b0}}, data[WIDTH-1:SHIFT]};
        ROT_SRA: result = {{SHIFT{data[WIDTH-1]}}, data[WIDTH-1:SHIFT]};
        default: result = data;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/lr_rot_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lr_rot_pipe : two-stage barrel rotator/shifter with valid/ready  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module lr_rot_pipe
  import rot_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  localparam int HA = AW / 2;

  logic             s1_valid;
  logic             s2_valid;
  logic             s2_adv;
  logic             in_xfer;
  rot_op_e          op_in;
  rot_op_e          s1_op;
  logic [HA-1:0]    s1_amt;
  logic [WIDTH-1:0] s1_data;
  logic             s1_carry;
  logic [WIDTH-1:0] rev;
  logic [WIDTH-1:0] hi_chain [HA:AW];
  logic [WIDTH-1:0] lo_chain [0:HA];
  logic [AW-1:0]    amt_neg;
  logic [AW-1:0]    amt_m1;
  logic             carry_src;

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign op_in     = rot_op_e'(in_op);

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign rev[i] = in_data[WIDTH-1-i];
  end

  // Reverse happens ahead of the layers; the layers pass REV through untouched.
  assign hi_chain[AW] = (op_in == ROT_REV) ? rev : in_data;

  for (genvar k = AW - 1; k >= HA; k--) begin : g_hi
    lr_rot_stage #(.WIDTH(WIDTH), .SHIFT(1 << k)) u_stage (
      .data  (hi_chain[k+1]),
      .en    (in_amt[k]),
      .op    (op_in),
      .result(hi_chain[k])
    );
  end

  assign lo_chain[HA] = s1_data;

  for (genvar k = HA - 1; k >= 0; k--) begin : g_lo
    lr_rot_stage #(.WIDTH(WIDTH), .SHIFT(1 << k)) u_stage (
      .data  (lo_chain[k+1]),
      .en    (s1_amt[k]),
      .op    (s1_op),
      .result(lo_chain[k])
    );
  end

  // The bit that falls off is picked straight from the operand: ROL/SHL lose
  // in[WIDTH-amt], ROR/SHR/SRA lose in[amt-1].
  assign amt_neg = AW'(0) - in_amt;
  assign amt_m1  = in_amt - AW'(1);

  always_comb begin
    carry_src = 1'b0;
    if (in_amt != '0) begin
      case (op_in)
        ROT_ROL, ROT_SHL:          carry_src = in_data[amt_neg];
        ROT_ROR, ROT_SHR, ROT_SRA: carry_src = in_data[amt_m1];
        default:                   carry_src = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= ROT_PASS;
      s1_amt   <= '0;
      s1_data  <= '0;
      s1_carry <= 1'b0;
    end else begin
      s1_valid <= in_xfer || (s1_valid && !s2_adv);
      if (in_xfer) begin
        s1_op    <= op_in;
        s1_amt   <= in_amt[HA-1:0];
        s1_data  <= hi_chain[HA];
        s1_carry <= carry_src;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= lo_chain[0];
        out_carry <= s1_carry;
        out_zero  <= ~|lo_chain[0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lr_rot_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_lr_rot_pipe : directed + randomized checks, WIDTH 8 and 32    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_lr_rot_pipe;

  typedef struct packed {
    logic [31:0] d;
    logic        c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        v8 = 1'b0, r8 = 1'b1, rdy8, ov8, oc8, oz8;
  logic [7:0]  d8 = '0, od8;
  logic [2:0]  a8 = '0, op8 = '0;

  logic        v32 = 1'b0, r32 = 1'b1, rdy32, ov32, oc32, oz32;
  logic [31:0] d32 = '0, od32;
  logic [4:0]  a32 = '0;
  logic [2:0]  op32 = '0;

  int tests = 0;
  int fails = 0;
  exp_t q8[$];
  exp_t q32[$];

  always #5 clk = ~clk;

  lr_rot_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
    .in_amt(a8), .in_op(op8), .out_valid(ov8), .out_ready(r8), .out_data(od8),
    .out_carry(oc8), .out_zero(oz8)
  );

  lr_rot_pipe #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .in_data(d32),
    .in_amt(a32), .in_op(op32), .out_valid(ov32), .out_ready(r32), .out_data(od32),
    .out_carry(oc32), .out_zero(oz32)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: straight arithmetic on a wide word, masked to w bits.
  function automatic exp_t model(input int w, input logic [31:0] d, input int amt, input int op);
    logic [63:0] m, dd, r;
    exp_t e;
    m  = (64'd1 << w) - 64'd1;
    dd = {32'd0, d} & m;
    r  = dd;
    case (op)
      1: r = ((dd << amt) | (dd >> (w - amt))) & m;
      2: r = ((dd >> amt) | (dd << (w - amt))) & m;
      3: r = (dd << amt) & m;
      4: r = dd >> amt;
      5: r = ((dd[w-1] ? (dd | ~m) : dd) >> amt) & m;
      6: begin
        r = '0;
        for (int i = 0; i < w; i++) r[i] = dd[w-1-i];
      end
      default: r = dd;
    endcase
    e.c = 1'b0;
    if (amt != 0) begin
      case (op)
        1:       e.c = r[0];
        2:       e.c = r[w-1];
        3:       e.c = dd[w-amt];
        4, 5:    e.c = dd[amt-1];
        default: e.c = 1'b0;
      endcase
    end
    e.d = r[31:0];
    return e;
  endfunction

  // Scoreboard for the 8-bit instance: occupancy, order, stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q8.delete();
    end else begin
      check("rdy8", 32'(rdy8), 32'(!(q8.size() == 2 && !r8)));
      if (ov8) begin
        check("occ8", 32'(q8.size() != 0), 32'd1);
        if (q8.size() != 0) begin
          e = q8[0];
          check("data8", 32'(od8), e.d);
          check("carry8", 32'(oc8), 32'(e.c));
          check("zero8", 32'(oz8), 32'(e.d[7:0] == 8'd0));
          if (r8) void'(q8.pop_front());
        end
      end
      if (v8 && rdy8) q8.push_back(model(8, {24'd0, d8}, int'(a8), int'(op8)));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q32.delete();
    end else begin
      check("rdy32", 32'(rdy32), 32'(!(q32.size() == 2 && !r32)));
      if (ov32) begin
        check("occ32", 32'(q32.size() != 0), 32'd1);
        if (q32.size() != 0) begin
          e = q32[0];
          check("data32", od32, e.d);
          check("carry32", 32'(oc32), 32'(e.c));
          check("zero32", 32'(oz32), 32'(e.d == 32'd0));
          if (r32) void'(q32.pop_front());
        end
      end
      if (v32 && rdy32) q32.push_back(model(32, d32, int'(a32), int'(op32)));
    end
  end

  task automatic directed8(input string tag, input logic [7:0] d, input logic [2:0] a,
                           input logic [2:0] op, input logic [7:0] ed, input logic ec);
    int n;
    @(posedge clk); #1;
    v8 = 1'b1; d8 = d; a8 = a; op8 = op; r8 = 1'b1;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(rdy8), 32'd1);
    @(posedge clk); #1;
    v8 = 1'b0; d8 = 'x; a8 = 'x; op8 = 'x;
    n = 1;
    @(negedge clk);
    while (!ov8 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd2);
    check({tag, "_data"}, 32'(od8), 32'(ed));
    check({tag, "_carry"}, 32'(oc8), 32'(ec));
    check({tag, "_zero"}, 32'(oz8), 32'(ed == 8'd0));
  endtask

  task automatic push32(input logic [31:0] d, input logic [4:0] a, input logic [2:0] op);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    v32 = 1'b1; d32 = d; a32 = a; op32 = op; r32 = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    while (!rdy32 && guard < 100) begin
      @(posedge clk); #1;
      r32 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      guard++;
    end
    check("push32_timeout", 32'(rdy32), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int sent, n;
    logic saw_full;

    #12;
    check("rst_ov", 32'(ov8), 32'd0);
    check("rst_od", 32'(od8), 32'd0);
    check("rst_oc", 32'(oc8), 32'd0);
    check("rst_oz", 32'(oz8), 32'd0);
    check("rst_rdy", 32'(rdy8), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    directed8("rol",  8'hB4, 3'd3, 3'b001, 8'hA5, 1'b1);
    directed8("ror",  8'hB4, 3'd3, 3'b010, 8'h96, 1'b1);
    directed8("shl",  8'hB4, 3'd3, 3'b011, 8'hA0, 1'b1);
    directed8("sra",  8'hB4, 3'd2, 3'b101, 8'hED, 1'b0);
    directed8("shr",  8'h01, 3'd1, 3'b100, 8'h00, 1'b1);
    directed8("rev",  8'hB4, 3'd5, 3'b110, 8'h2D, 1'b0);
    directed8("rsvd", 8'h5A, 3'd4, 3'b111, 8'h5A, 1'b0);
    directed8("rol0", 8'hB4, 3'd0, 3'b001, 8'hB4, 1'b0);
    directed8("shr0", 8'h81, 3'd0, 3'b100, 8'h81, 1'b0);
    directed8("sra7", 8'h80, 3'd7, 3'b101, 8'hFF, 1'b0);

    // Back-to-back stream with a downstream stall in cycles 3..6.
    sent = 0;
    saw_full = 1'b0;
    for (int cyc = 0; cyc < 60 && (sent < 16 || q8.size() != 0); cyc++) begin
      @(posedge clk); #1;
      r8  = !(cyc >= 3 && cyc <= 6);
      v8  = (sent < 16);
      d8  = 8'($urandom);
      a8  = 3'($urandom);
      op8 = 3'($urandom);
      @(negedge clk);
      if (v8 && rdy8) sent++;
      if (!r8 && !rdy8) saw_full = 1'b1;
    end
    v8 = 1'b0; r8 = 1'b1;
    check("stream_sent", 32'(sent), 32'd16);
    check("stream_drain", 32'(q8.size()), 32'd0);
    check("stream_full", 32'(saw_full), 32'd1);

    // Reset with two operations in flight.
    @(posedge clk); #1;
    r8 = 1'b0; v8 = 1'b1; d8 = 8'h3C; a8 = 3'd1; op8 = 3'b001;
    @(posedge clk); #1;
    d8 = 8'hC3; a8 = 3'd2; op8 = 3'b010;
    @(posedge clk); #1;
    v8 = 1'b0;
    @(negedge clk);
    check("inflight_ov", 32'(ov8), 32'd1);
    check("inflight_rdy", 32'(rdy8), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_ov", 32'(ov8), 32'd0);
    check("arst_od", 32'(od8), 32'd0);
    check("arst_oc", 32'(oc8), 32'd0);
    check("arst_rdy", 32'(rdy8), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1; r8 = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", 32'(rdy8), 32'd1);
    check("post_rst_ov", 32'(ov8), 32'd0);
    directed8("post_rst", 8'hB4, 3'd3, 3'b001, 8'hA5, 1'b1);

    // WIDTH=32: every op at every amount, random backpressure.
    for (int op = 0; op < 8; op++) begin
      for (int a = 0; a < 32; a++) begin
        push32($urandom, 5'(a), 3'(op));
      end
    end
    @(posedge clk); #1;
    v32 = 1'b0; r32 = 1'b1;
    n = 0;
    while (q32.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("w32_drain", 32'(q32.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
